// File: rtl/dcs_frame_master.sv
// ---------------------------------------------------------------------------
// dcs_frame_master
//
// Host-side driver for the DCSformer streaming protocol. A local register
// port fills an 8x16 byte input matrix and an 8-byte weight vector. A start
// pulse launches one frame:
//   1. stream the 128 matrix bytes on i_valid/i_data with no gaps,
//   2. wait for the responder's w_ready pulse,
//   3. stream the 8 weight bytes on w_valid/w_data,
//   4. capture 8 result words from o_valid/o_data into a readable buffer.
// A watchdog aborts the frame with err if WAIT_W or COLLECT stalls.
//
// Handshake semantics: the responder has no back-pressure on the i/w
// streams. A beat is transferred on every cycle its valid is high, and
// i_valid falling marks end-of-matrix. w_ready is a single-cycle request
// from the responder and is acted on only in WAIT_W. o_valid beats are
// always accepted; beats outside COLLECT are protocol errors.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   wr_en/addr/data   buffer write port (IDLE only); 0..127 matrix, 128..135 weights
//   start             one-cycle launch request (IDLE only)
//   rd_addr, rd_data  combinational read of the result buffer
//   busy, done, err   frame status (err is sticky until the next start)
//   i_valid, i_data   registered matrix stream to the responder
//   w_valid, w_data   registered weight stream to the responder
//   w_ready           responder weight-request pulse
//   o_valid, o_data   responder result stream
//   dbg_state         current FSM state encoding
// ---------------------------------------------------------------------------
module dcs_frame_master #(
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [7:0]  wr_addr,
  input  logic [7:0]  wr_data,
  input  logic        start,
  input  logic [2:0]  rd_addr,
  output logic [31:0] rd_data,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        i_valid,
  output logic [7:0]  i_data,
  output logic        w_valid,
  output logic [7:0]  w_data,
  input  logic        w_ready,
  input  logic        o_valid,
  input  logic [31:0] o_data,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SEND_I  = 3'd1,
    WAIT_W  = 3'd2,
    SEND_W  = 3'd3,
    COLLECT = 3'd4,
    DONE    = 3'd5
  } state_t;

  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  state_t          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [WDW-1:0]  wdog_q, wdog_d;
  logic            err_q, err_d;
  logic            i_valid_q, i_valid_d;
  logic [7:0]      i_data_q, i_data_d;
  logic            w_valid_q, w_valid_d;
  logic [7:0]      w_data_q, w_data_d;
  logic            cap_en;
  logic            clr_res;

  logic [7:0]      matrix [128];
  logic [7:0]      weight [8];
  logic [31:0]     result [8];

  logic            wr_ok;
  logic            wr_mat;
  logic            wr_wt;
  logic [7:0]      m0_now;

  assign wr_ok  = wr_en && (state_q == IDLE);
  assign wr_mat = wr_ok && !wr_addr[7];
  assign wr_wt  = wr_ok && (wr_addr[7:3] == 5'b10000);

  // The first matrix byte is registered on the same edge that accepts
  // start, so a write to byte 0 on that edge must be forwarded here to be
  // part of the launched frame.
  assign m0_now = (wr_mat && (wr_addr[6:0] == 7'd0)) ? wr_data : matrix[0];

  // -------------------------------------------------------------------------
  // Next-state and next-output logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wdog_d    = wdog_q;
    err_d     = err_q;
    i_valid_d = 1'b0;
    i_data_d  = 8'd0;
    w_valid_d = 1'b0;
    w_data_d  = 8'd0;
    cap_en    = 1'b0;
    clr_res   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = SEND_I;
          cnt_d     = 8'd1;
          i_valid_d = 1'b1;
          i_data_d  = m0_now;
          err_d     = 1'b0;
          clr_res   = 1'b1;
        end else if (o_valid) begin
          err_d = 1'b1;
        end
      end

      // cnt_q is the index of the byte to put on the wire next cycle.
      SEND_I: begin
        if (cnt_q == 8'd128) begin
          state_d = WAIT_W;
          cnt_d   = 8'd0;
          wdog_d  = '0;
        end else begin
          i_valid_d = 1'b1;
          i_data_d  = matrix[cnt_q[6:0]];
          cnt_d     = cnt_q + 8'd1;
        end
      end

      WAIT_W: begin
        if (w_ready) begin
          state_d   = SEND_W;
          w_valid_d = 1'b1;
          w_data_d  = weight[0];
          cnt_d     = 8'd1;
        end else if (wdog_q == WD_LAST) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          wdog_d = wdog_q + WDW'(1);
        end
      end

      SEND_W: begin
        if (cnt_q == 8'd8) begin
          state_d = COLLECT;
          cnt_d   = 8'd0;
          wdog_d  = '0;
        end else begin
          w_valid_d = 1'b1;
          w_data_d  = weight[cnt_q[2:0]];
          cnt_d     = cnt_q + 8'd1;
        end
      end

      // cnt_q counts captured result beats.
      COLLECT: begin
        if (o_valid) begin
          cap_en = 1'b1;
          wdog_d = '0;
          cnt_d  = cnt_q + 8'd1;
          if (cnt_q == 8'd7) begin
            state_d = DONE;
          end
        end else if (wdog_q == WD_LAST) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          wdog_d = wdog_q + WDW'(1);
        end
      end

      DONE: begin
        state_d = IDLE;
        if (o_valid) begin
          err_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Control and stream registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      wdog_q    <= '0;
      err_q     <= 1'b0;
      i_valid_q <= 1'b0;
      i_data_q  <= 8'd0;
      w_valid_q <= 1'b0;
      w_data_q  <= 8'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wdog_q    <= wdog_d;
      err_q     <= err_d;
      i_valid_q <= i_valid_d;
      i_data_q  <= i_data_d;
      w_valid_q <= w_valid_d;
      w_data_q  <= w_data_d;
    end
  end

  // -------------------------------------------------------------------------
  // Matrix, weight and result buffers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 128; i++) matrix[i] <= 8'd0;
      for (int i = 0; i < 8; i++)   weight[i] <= 8'd0;
    end else begin
      if (wr_mat) matrix[wr_addr[6:0]] <= wr_data;
      if (wr_wt)  weight[wr_addr[2:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) result[i] <= 32'd0;
    end else if (clr_res) begin
      for (int i = 0; i < 8; i++) result[i] <= 32'd0;
    end else if (cap_en) begin
      result[cnt_q[2:0]] <= o_data;
    end
  end

  assign rd_data   = result[rd_addr];
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign err       = err_q;
  assign i_valid   = i_valid_q;
  assign i_data    = i_data_q;
  assign w_valid   = w_valid_q;
  assign w_data    = w_data_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_dcs_frame_master.sv
// ---------------------------------------------------------------------------
// tb_dcs_frame_master
//
// Directed bench for dcs_frame_master. The bench plays the responder:
// it records the i/w streams, pulses w_ready, and supplies hand-chosen
// result words, then checks stream contents, timing and status flags.
// ---------------------------------------------------------------------------
module tb_dcs_frame_master;

  // Clock / reset and DUT signals
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [7:0]  wr_addr = 8'd0;
  logic [7:0]  wr_data = 8'd0;
  logic        start = 1'b0;
  logic [2:0]  rd_addr = 3'd0;
  logic [31:0] rd_data;
  logic        busy, done, err;
  logic        i_valid, w_valid;
  logic [7:0]  i_data, w_data;
  logic        w_ready = 1'b0;
  logic        o_valid = 1'b0;
  logic [31:0] o_data = 32'd0;
  logic [2:0]  dbg_state;

  always #5 clk = ~clk;

  dcs_frame_master #(.TIMEOUT(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .rd_addr(rd_addr), .rd_data(rd_data),
    .busy(busy), .done(done), .err(err),
    .i_valid(i_valid), .i_data(i_data),
    .w_valid(w_valid), .w_data(w_data),
    .w_ready(w_ready), .o_valid(o_valid), .o_data(o_data),
    .dbg_state(dbg_state)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  cap_i[$];
  logic [7:0]  cap_w[$];
  logic [31:0] res_drv[8];
  int          ni, nw;

  // Expected buffer contents for each load pattern
  function automatic logic [7:0] mat_val(input int mode, input int idx);
    case (mode)
      0:       return 8'(idx / 16 + 1);
      1:       return 8'd1;
      default: return 8'(idx) ^ 8'h5A;
    endcase
  endfunction

  function automatic logic [7:0] wt_val(input int mode, input int k);
    case (mode)
      0:       return 8'd1;
      1:       return 8'd5;
      default: return 8'(8'h10 + k);
    endcase
  endfunction

  // ---------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic write_byte(input logic [7:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic load_frame(input int mode);
    for (int i = 0; i < 128; i++) write_byte(8'(i), mat_val(mode, i));
    for (int k = 0; k < 8; k++) write_byte(8'(128 + k), wt_val(mode, k));
  endtask

  // Launch, optionally with a same-cycle write to matrix byte 0.
  task automatic launch(input bit with_wr, input logic [7:0] v);
    start = 1'b1;
    if (with_wr) begin wr_en = 1'b1; wr_addr = 8'd0; wr_data = v; end
    tick();
    start = 1'b0; wr_en = 1'b0;
  endtask

  task automatic grab_i();
    cap_i.delete(); ni = 0;
    while (i_valid === 1'b1 && ni < 200) begin
      cap_i.push_back(i_data); ni++; tick();
    end
  endtask

  task automatic grab_w();
    cap_w.delete(); nw = 0;
    while (w_valid === 1'b1 && nw < 20) begin
      cap_w.push_back(w_data); nw++; tick();
    end
  endtask

  task automatic pulse_w();
    w_ready = 1'b1; tick(); w_ready = 1'b0;
  endtask

  // Ends in the cycle after the 8th beat was sampled.
  task automatic send_results(input int gap);
    for (int k = 0; k < 8; k++) begin
      repeat (gap) tick();
      o_valid = 1'b1; o_data = res_drv[k];
      tick();
      o_valid = 1'b0; o_data = 32'd0;
    end
  endtask

  task automatic frame(input int gap, input bit with_wr, input logic [7:0] v);
    launch(with_wr, v);
    grab_i();
    pulse_w();
    grab_w();
    send_results(gap);
  endtask

  // ---------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------
  task automatic test_reset();
    do_reset();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", done); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b want 0", err); end
    vectors++; if ({i_valid, w_valid} !== 2'b00) begin miscompares++; $display("FAIL reset_valids: got %b want 00", {i_valid, w_valid}); end
    vectors++; if ({i_data, w_data} !== 16'h0) begin miscompares++; $display("FAIL reset_data: got %h want 0000", {i_data, w_data}); end
    for (int k = 0; k < 8; k++) begin
      rd_addr = 3'(k); #1;
      vectors++; if (rd_data !== 32'd0) begin miscompares++; $display("FAIL reset_result[%0d]: got %h want 0", k, rd_data); end
    end
  endtask

  task automatic test_frame();
    load_frame(0);
    for (int k = 0; k < 8; k++) res_drv[k] = 32'(416 * (k + 1));
    launch(1'b0, 8'h00);
    vectors++; if (busy !== 1'b1 || i_valid !== 1'b1) begin miscompares++; $display("FAIL frame_launch: busy=%b i_valid=%b want 1 1", busy, i_valid); end
    grab_i();
    vectors++; if (ni != 128) begin miscompares++; $display("FAIL frame_i_beats: got %0d want 128", ni); end
    for (int i = 0; i < ni && i < 128; i++) begin
      vectors++; if (cap_i[i] !== mat_val(0, i)) begin miscompares++; $display("FAIL frame_i_data[%0d]: got %h want %h", i, cap_i[i], mat_val(0, i)); end
    end
    vectors++; if (i_data !== 8'd0) begin miscompares++; $display("FAIL frame_i_idle_data: got %h want 00", i_data); end
    pulse_w();
    grab_w();
    vectors++; if (nw != 8) begin miscompares++; $display("FAIL frame_w_beats: got %0d want 8", nw); end
    for (int k = 0; k < nw && k < 8; k++) begin
      vectors++; if (cap_w[k] !== 8'd1) begin miscompares++; $display("FAIL frame_w_data[%0d]: got %h want 01", k, cap_w[k]); end
    end
    vectors++; if (w_data !== 8'd0) begin miscompares++; $display("FAIL frame_w_idle_data: got %h want 00", w_data); end
    send_results(2);
    vectors++; if (done !== 1'b1 || busy !== 1'b1) begin miscompares++; $display("FAIL frame_done: done=%b busy=%b want 1 1", done, busy); end
    tick();
    vectors++; if (done !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin miscompares++; $display("FAIL frame_end: done=%b busy=%b err=%b want 0 0 0", done, busy, err); end
    for (int k = 0; k < 8; k++) begin
      rd_addr = 3'(k); #1;
      vectors++; if (rd_data !== 32'(416 * (k + 1))) begin miscompares++; $display("FAIL frame_result[%0d]: got %0d want %0d", k, rd_data, 416 * (k + 1)); end
    end
  endtask

  // Starts in the first cycle busy is low after the previous frame.
  task automatic test_back_to_back();
    for (int k = 0; k < 8; k++) res_drv[k] = 32'hC000_0000 + 32'(k);
    launch(1'b1, 8'hEE);
    grab_i();
    vectors++; if (ni != 128) begin miscompares++; $display("FAIL b2b_i_beats: got %0d want 128", ni); end
    vectors++; if (cap_i[0] !== 8'hEE) begin miscompares++; $display("FAIL b2b_same_cycle_write: got %h want ee", cap_i[0]); end
    // Writes while busy must be dropped.
    write_byte(8'd1, 8'h77);
    write_byte(8'd128, 8'h99);
    pulse_w();
    grab_w();
    vectors++; if (nw != 8 || cap_w[0] !== 8'd1) begin miscompares++; $display("FAIL b2b_w: beats=%0d w0=%h want 8 01", nw, cap_w[0]); end
    send_results(0);
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL b2b_done: got %b want 1", done); end
    tick();
    rd_addr = 3'd5; #1;
    vectors++; if (rd_data !== 32'hC000_0005) begin miscompares++; $display("FAIL b2b_result5: got %h want c0000005", rd_data); end
  endtask

  task automatic test_delay();
    int bad;
    for (int k = 0; k < 8; k++) res_drv[k] = 32'(3 * k + 7);
    launch(1'b0, 8'h00);
    grab_i();
    vectors++; if (cap_i[0] !== 8'hEE || cap_i[1] !== 8'd1) begin miscompares++; $display("FAIL delay_ignored_write: got %h %h want ee 01", cap_i[0], cap_i[1]); end
    bad = 0;
    for (int c = 0; c < 50; c++) begin
      if (i_valid !== 1'b0 || w_valid !== 1'b0) bad++;
      tick();
    end
    vectors++; if (bad != 0) begin miscompares++; $display("FAIL delay_valids_low: got %0d active cycles want 0", bad); end
    vectors++; if (busy !== 1'b1 || err !== 1'b0) begin miscompares++; $display("FAIL delay_waiting: busy=%b err=%b want 1 0", busy, err); end
    pulse_w();
    vectors++; if (w_valid !== 1'b1 || w_data !== 8'd1) begin miscompares++; $display("FAIL delay_w_start: w_valid=%b w_data=%h want 1 01", w_valid, w_data); end
    grab_w();
    vectors++; if (nw != 8) begin miscompares++; $display("FAIL delay_w_beats: got %0d want 8", nw); end
    send_results(1);
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL delay_done: got %b want 1", done); end
    tick();
    rd_addr = 3'd7; #1;
    vectors++; if (rd_data !== 32'd28) begin miscompares++; $display("FAIL delay_result7: got %0d want 28", rd_data); end
  endtask

  task automatic test_zero();
    load_frame(1);
    for (int k = 0; k < 8; k++) res_drv[k] = 32'd0;
    frame(0, 1'b0, 8'h00);
    vectors++; if (ni != 128 || nw != 8) begin miscompares++; $display("FAIL zero_beats: got %0d/%0d want 128/8", ni, nw); end
    vectors++; if (cap_i[77] !== 8'd1 || cap_w[3] !== 8'd5) begin miscompares++; $display("FAIL zero_stream_data: got %h %h want 01 05", cap_i[77], cap_w[3]); end
    vectors++; if (done !== 1'b1 || err !== 1'b0) begin miscompares++; $display("FAIL zero_done: done=%b err=%b want 1 0", done, err); end
    tick();
    for (int k = 0; k < 8; k++) begin
      rd_addr = 3'(k); #1;
      vectors++; if (rd_data !== 32'd0) begin miscompares++; $display("FAIL zero_result[%0d]: got %h want 0", k, rd_data); end
    end
  endtask

  task automatic test_timeout();
    int seen_done;
    // WAIT_W stall: first WAIT_W cycle is the one grab_i ends in.
    launch(1'b0, 8'h00);
    grab_i();
    seen_done = 0;
    for (int c = 0; c < 63; c++) begin
      if (done === 1'b1) seen_done++;
      tick();
    end
    vectors++; if (err !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("FAIL to_w_before: err=%b busy=%b want 0 1", err, busy); end
    tick();
    vectors++; if (err !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin miscompares++; $display("FAIL to_w_abort: err=%b busy=%b done=%b want 1 0 0", err, busy, done); end
    vectors++; if (seen_done != 0) begin miscompares++; $display("FAIL to_w_no_done: got %0d pulses want 0", seen_done); end
    tick();
    // COLLECT stall after three beats.
    launch(1'b0, 8'h00);
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL to_start_clears_err: got %b want 0", err); end
    grab_i();
    pulse_w();
    grab_w();
    for (int k = 0; k < 3; k++) begin
      o_valid = 1'b1; o_data = 32'hA1 + 32'(k); tick();
    end
    o_valid = 1'b0; o_data = 32'd0;
    repeat (63) tick();
    vectors++; if (err !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("FAIL to_c_before: err=%b busy=%b want 0 1", err, busy); end
    tick();
    vectors++; if (err !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin miscompares++; $display("FAIL to_c_abort: err=%b busy=%b done=%b want 1 0 0", err, busy, done); end
    rd_addr = 3'd2; #1;
    vectors++; if (rd_data !== 32'hA3) begin miscompares++; $display("FAIL to_c_kept: got %h want a3", rd_data); end
    rd_addr = 3'd3; #1;
    vectors++; if (rd_data !== 32'd0) begin miscompares++; $display("FAIL to_c_unfilled: got %h want 0", rd_data); end
  endtask

  task automatic test_extra();
    for (int k = 0; k < 8; k++) res_drv[k] = 32'(k + 1);
    frame(0, 1'b0, 8'h00);
    vectors++; if (done !== 1'b1 || err !== 1'b0) begin miscompares++; $display("FAIL extra_done: done=%b err=%b want 1 0", done, err); end
    o_valid = 1'b1; o_data = 32'd9;
    tick();
    o_valid = 1'b0; o_data = 32'd0;
    vectors++; if (err !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL extra_err: err=%b done=%b busy=%b want 1 0 0", err, done, busy); end
    tick();
    vectors++; if (done !== 1'b0 || err !== 1'b1) begin miscompares++; $display("FAIL extra_sticky: done=%b err=%b want 0 1", done, err); end
    for (int k = 0; k < 8; k++) begin
      rd_addr = 3'(k); #1;
      vectors++; if (rd_data !== 32'(k + 1)) begin miscompares++; $display("FAIL extra_result[%0d]: got %0d want %0d", k, rd_data, k + 1); end
    end
  endtask

  task automatic test_reset_mid();
    launch(1'b0, 8'h00);
    repeat (59) tick();
    vectors++; if (i_valid !== 1'b1) begin miscompares++; $display("FAIL rstmid_beat60: i_valid=%b want 1", i_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++; if (i_valid !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin miscompares++; $display("FAIL rstmid_async: i_valid=%b busy=%b err=%b want 0 0 0", i_valid, busy, err); end
    rd_addr = 3'd7; #1;
    vectors++; if (rd_data !== 32'd0) begin miscompares++; $display("FAIL rstmid_result: got %h want 0", rd_data); end
    tick();
    rst_n = 1'b1;
    tick();
    // Buffers were cleared: an unloaded frame streams zeros.
    for (int k = 0; k < 8; k++) res_drv[k] = 32'd0;
    frame(0, 1'b0, 8'h00);
    vectors++; if (ni != 128 || nw != 8) begin miscompares++; $display("FAIL rstmid_zero_beats: got %0d/%0d want 128/8", ni, nw); end
    vectors++; if (cap_i[0] !== 8'd0 || cap_i[127] !== 8'd0 || cap_w[0] !== 8'd0) begin miscompares++; $display("FAIL rstmid_zero_bufs: got %h %h %h want 00 00 00", cap_i[0], cap_i[127], cap_w[0]); end
    tick();
    // Full frame with a fresh pattern.
    load_frame(2);
    for (int k = 0; k < 8; k++) res_drv[k] = 32'h1234_0000 + 32'(k * 17);
    frame(1, 1'b0, 8'h00);
    vectors++; if (ni != 128 || nw != 8) begin miscompares++; $display("FAIL rstmid_beats: got %0d/%0d want 128/8", ni, nw); end
    for (int i = 0; i < ni && i < 128; i += 9) begin
      vectors++; if (cap_i[i] !== mat_val(2, i)) begin miscompares++; $display("FAIL rstmid_i_data[%0d]: got %h want %h", i, cap_i[i], mat_val(2, i)); end
    end
    for (int k = 0; k < nw && k < 8; k++) begin
      vectors++; if (cap_w[k] !== wt_val(2, k)) begin miscompares++; $display("FAIL rstmid_w_data[%0d]: got %h want %h", k, cap_w[k], wt_val(2, k)); end
    end
    vectors++; if (done !== 1'b1 || err !== 1'b0) begin miscompares++; $display("FAIL rstmid_done: done=%b err=%b want 1 0", done, err); end
    tick();
    rd_addr = 3'd6; #1;
    vectors++; if (rd_data !== 32'h1234_0066) begin miscompares++; $display("FAIL rstmid_result6: got %h want 12340066", rd_data); end
  endtask

  // ---------------------------------------------------------------------
  // Sequence and final report
  // ---------------------------------------------------------------------
  initial begin
    test_reset();
    test_frame();
    test_back_to_back();
    test_delay();
    test_zero();
    test_timeout();
    test_extra();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_time_limit: run did not complete, vectors=%0d", vectors);
    $fatal(1);
  end

endmodule
